// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//   Fetch stage of a 32-bit MIPS pipeline. Holds the program counter, presents
//   it as the byte address to a combinational instruction memory, and captures
//   the returned word into the IF/ID pipeline register. Supports hazard stalls,
//   branch/jump redirect with IF/ID flush, and halting once the PC leaves the
//   program space (pc >= HALT_ADDR). A redirect leaves the halted state.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   stall          in   hold PC and IF/ID this cycle
//   branch_taken   in   redirect to branch_target (priority over jump)
//   branch_target  in   branch destination byte address (low 2 bits ignored)
//   jump           in   redirect to {jump_index, 2'b00}
//   jump_index     in   J-type instr_index field
//   instr_addr     out  byte address to instruction memory (= pc)
//   instr_data     in   word returned combinationally by instruction memory
//   if_id_instr    out  registered instruction for decode
//   if_id_pc4      out  registered PC+4 of that instruction
//   if_id_valid    out  if_id_instr holds a real fetched instruction
//   halted         out  fetch has reached HALT_ADDR
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_fetch_stage #(
   parameter int unsigned                ADDR_WIDTH = 28,
   parameter int unsigned                DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0,
   parameter int unsigned                HALT_ADDR  = 372
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-3:0] jump_index,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0] instr_data,
   output logic [DATA_WIDTH-1:0] if_id_instr,
   output logic [ADDR_WIDTH-1:0] if_id_pc4,
   output logic                  if_id_valid,
   output logic                  halted
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic [ADDR_WIDTH-1:0]   w_pc_next;
   logic [DATA_WIDTH-1:0]   r_instr;
   logic [DATA_WIDTH-1:0]   w_instr_next;
   logic [ADDR_WIDTH-1:0]   r_pc4;
   logic [ADDR_WIDTH-1:0]   w_pc4_next;
   logic                    r_valid;
   logic                    w_valid_next;

   logic [ADDR_WIDTH-1:0]   w_pc_plus4;
   logic [ADDR_WIDTH-1:0]   w_branch_aligned;
   logic [ADDR_WIDTH-1:0]   w_redirect_target;
   logic                    w_redirect;
   logic                    w_below_halt;

   // Natural-width add: carry out of the top bit is dropped, so the PC wraps
   // silently at the top of the address space.
   assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

   // Branch targets are forced word-aligned by masking the two low bits.
   assign w_branch_aligned  = branch_target & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   // Branch wins over jump: the branch is the older instruction in the pipe.
   assign w_redirect_target = branch_taken ? w_branch_aligned : {jump_index, 2'b00};
   assign w_redirect        = branch_taken | jump;

   // One extra bit so a HALT_ADDR of exactly 2**ADDR_WIDTH (never halt) works.
   assign w_below_halt = ({1'b0, r_pc} < (ADDR_WIDTH+1)'(HALT_ADDR));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_instr_next = r_instr;
      w_pc4_next   = r_pc4;
      w_valid_next = r_valid;
      if (w_redirect) begin
         // Flush IF/ID with a NOP; redirect also overrides stall and halt.
         w_state_next = ST_RUN;
         w_pc_next    = w_redirect_target;
         w_instr_next = '0;
         w_pc4_next   = '0;
         w_valid_next = 1'b0;
      end else if (stall) begin
         // Everything holds (defaults).
      end else if (r_state == ST_RUN) begin
         if (w_below_halt) begin
            w_pc_next    = w_pc_plus4;
            w_instr_next = instr_data;
            w_pc4_next   = w_pc_plus4;
            w_valid_next = 1'b1;
         end else begin
            w_state_next = ST_HALTED;
            w_instr_next = '0;
            w_pc4_next   = '0;
            w_valid_next = 1'b0;
         end
      end else begin
         // HALTED: PC holds, IF/ID keeps presenting an invalid NOP.
         w_instr_next = '0;
         w_pc4_next   = '0;
         w_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_pc    <= w_pc_next;
         r_instr <= w_instr_next;
         r_pc4   <= w_pc4_next;
         r_valid <= w_valid_next;
      end
   end

   assign instr_addr  = r_pc;
   assign if_id_instr = r_instr;
   assign if_id_pc4   = r_pc4;
   assign if_id_valid = r_valid;
   assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
`timescale 1ns/1ps

module tb_instruction_fetch_stage;

   localparam int unsigned HALT = 372;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [27:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = '0;
   logic [27:0] instr_addr;
   logic [31:0] instr_data;
   logic [31:0] if_id_instr;
   logic [27:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;

   // Second instance that never halts, used to observe PC wrap-around.
   logic [27:0] w_addr;
   logic [31:0] w_data;
   logic [31:0] w_instr;
   logic [27:0] w_pc4;
   logic        w_valid;
   logic        w_halted;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] instr;
      logic [27:0] pc4;
      logic        valid;
   } exp_t;
   exp_t sb[$];

   // Model state
   logic [27:0] m_pc = '0;
   logic        m_halt = 1'b0;
   exp_t        m_e;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [27:0] a);
      if (a == 28'd0) return 32'h2008_0000;
      return {4'hA, a};
   endfunction

   assign instr_data = mem_word(instr_addr);
   assign w_data     = mem_word(w_addr);

   instruction_fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
      .instr_addr(instr_addr), .instr_data(instr_data), .if_id_instr(if_id_instr),
      .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted)
   );

   instruction_fetch_stage #(.HALT_ADDR(32'h1000_0000)) u_wrap (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
      .instr_addr(w_addr), .instr_data(w_data), .if_id_instr(w_instr),
      .if_id_pc4(w_pc4), .if_id_valid(w_valid), .halted(w_halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: each cycle the DUT presents IF/ID contents; compare to scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (if_id_valid !== e.valid || if_id_instr !== e.instr || if_id_pc4 !== e.pc4) begin
               errors++;
               $display("FAIL ifid: got v=%0b instr=0x%08h pc4=0x%07h expected v=%0b instr=0x%08h pc4=0x%07h",
                        if_id_valid, if_id_instr, if_id_pc4, e.valid, e.instr, e.pc4);
            end else begin
               $display("ifid ok: v=%0b instr=0x%08h pc4=0x%07h", e.valid, e.instr, e.pc4);
            end
         end
      end
   end

   // One clock of stimulus: apply inputs, advance the model, push expectation.
   task automatic step(input logic s, input logic br, input logic [27:0] bt,
                       input logic j, input logic [25:0] ji);
      stall = s; branch_taken = br; branch_target = bt; jump = j; jump_index = ji;
      if (br || j) begin
         m_pc   = br ? {bt[27:2], 2'b00} : {ji, 2'b00};
         m_halt = 1'b0;
         m_e    = '{instr: 32'h0, pc4: 28'h0, valid: 1'b0};
      end else if (s) begin
         // hold
      end else if (!m_halt && m_pc < 28'(HALT)) begin
         m_e  = '{instr: mem_word(m_pc), pc4: m_pc + 28'd4, valid: 1'b1};
         m_pc = m_pc + 28'd4;
      end else begin
         m_halt = 1'b1;
         m_e    = '{instr: 32'h0, pc4: 28'h0, valid: 1'b0};
      end
      @(posedge clk);
      #1;
      sb.push_back(m_e);
      chk("instr_addr", {4'h0, instr_addr}, {4'h0, m_pc});
      chk("halted", {31'h0, halted}, {31'h0, m_halt});
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
   endtask

   task automatic free_run();
      step(1'b0, 1'b0, 28'h0, 1'b0, 26'h0);
   endtask

   initial begin
      m_e = '{instr: 32'h0, pc4: 28'h0, valid: 1'b0};
      #1;
      chk("rst_addr", {4'h0, instr_addr}, 32'h0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_pc4", {4'h0, if_id_pc4}, 32'h0);
      chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Free run from 0
      free_run();
      chk("edge1_instr", if_id_instr, 32'h2008_0000);
      chk("edge1_pc4", {4'h0, if_id_pc4}, 32'd4);
      chk("edge1_valid", {31'h0, if_id_valid}, 32'd1);
      free_run();
      chk("pc_8", {4'h0, instr_addr}, 32'd8);

      // Stall two cycles at pc=8
      step(1'b1, 1'b0, 28'h0, 1'b0, 26'h0);
      step(1'b1, 1'b0, 28'h0, 1'b0, 26'h0);
      chk("stall_pc", {4'h0, instr_addr}, 32'd8);
      chk("stall_pc4", {4'h0, if_id_pc4}, 32'd8);
      free_run();
      chk("release_pc", {4'h0, instr_addr}, 32'd12);

      // Branch with stall and jump in the same cycle
      step(1'b1, 1'b1, 28'h2C, 1'b1, 26'h3F);
      chk("br_pc", {4'h0, instr_addr}, 32'h2C);
      chk("br_valid", {31'h0, if_id_valid}, 32'd0);
      chk("br_instr", if_id_instr, 32'h0);
      free_run();
      chk("br_fetch_instr", if_id_instr, 32'hA000_002C);
      chk("br_fetch_pc4", {4'h0, if_id_pc4}, 32'h30);

      // Jump
      step(1'b0, 1'b0, 28'h0, 1'b1, 26'h5);
      chk("jmp_pc", {4'h0, instr_addr}, 32'h14);
      chk("jmp_valid", {31'h0, if_id_valid}, 32'd0);

      // Run to HALT_ADDR
      for (int i = 0; i < 200 && m_pc < 28'(HALT); i++) free_run();
      chk("at_halt_pc", {4'h0, instr_addr}, 32'd372);
      chk("at_halt_valid", {31'h0, if_id_valid}, 32'd1);
      free_run();
      chk("halted_set", {31'h0, halted}, 32'd1);
      chk("halted_valid", {31'h0, if_id_valid}, 32'd0);
      free_run();
      chk("halted_pc_hold", {4'h0, instr_addr}, 32'd372);

      // Jump to 0 exits halt
      step(1'b0, 1'b0, 28'h0, 1'b1, 26'h0);
      chk("unhalt", {31'h0, halted}, 32'd0);
      chk("unhalt_pc", {4'h0, instr_addr}, 32'd0);
      free_run();
      chk("resume_instr", if_id_instr, 32'h2008_0000);

      // Unaligned branch target
      step(1'b0, 1'b1, 28'h31, 1'b0, 26'h0);
      chk("unaligned_pc", {4'h0, instr_addr}, 32'h30);

      // Top of address space: default instance halts, never-halt instance wraps
      step(1'b0, 1'b1, 28'hFFF_FFFC, 1'b0, 26'h0);
      chk("top_pc", {4'h0, instr_addr}, 32'h0FFF_FFFC);
      free_run();
      chk("top_halted", {31'h0, halted}, 32'd1);
      chk("wrap_pc", {4'h0, w_addr}, 32'h0);
      chk("wrap_pc4", {4'h0, w_pc4}, 32'h0);
      chk("wrap_instr", w_instr, 32'hAFFF_FFFC);
      free_run();
      chk("wrap_pc_next", {4'h0, w_addr}, 32'd4);

      // Drain scoreboard
      @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);

      // Asynchronous reset mid-cycle
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("arst_addr", {4'h0, instr_addr}, 32'h0);
      chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("arst_halted", {31'h0, halted}, 32'h0);
      chk("arst_wrap_addr", {4'h0, w_addr}, 32'h0);
      chk("arst_wrap_instr", w_instr, 32'h0);
      #10;
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
